// File: rtl/product_accumulator.sv
// Accumulates unsigned multiplier products into a guarded sum and presents one
// result per vector (the vector ends on the term flagged prod_last).
module product_accumulator #(
  parameter int PW    = 64,
  parameter int GUARD = 8,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PW-1:0]       Product,
  input  logic                prod_valid,
  input  logic                prod_last,
  output logic                prod_ready,
  input  logic                clear,
  output logic [PW+GUARD-1:0] Sum,
  output logic [CW-1:0]       Count,
  output logic                Ovf,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int AW = PW + GUARD;

  typedef enum logic {ACC, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          accept;
  logic [AW-1:0] term;
  logic [AW:0]   sum_next;
  logic [CW-1:0] cnt_inc;

  // In DONE a new term is only taken when the pending result retires in the same cycle.
  assign prod_ready = rst_n & ((state == ACC) | out_ready);
  assign accept     = prod_valid & prod_ready;
  assign term       = {{GUARD{1'b0}}, Product};
  assign sum_next   = {1'b0, acc} + {1'b0, term};
  assign cnt_inc    = (&cnt) ? cnt : cnt + CW'(1);

  assign Sum   = acc;
  assign Count = cnt;
  assign Ovf   = ovf;

  // NOTE: all state is registered with non-blocking assignments and a reset
  // sampled on the clock edge, so reset is simply the highest-priority branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (clear) begin
            cnt <= '0;
            ovf <= 1'b0;
          end else if (accept) begin
            if (cnt == '0) begin
              acc <= term;
              cnt <= CW'(1);
              ovf <= 1'b0;
            end else begin
              acc <= sum_next[AW-1:0];
              ovf <= ovf | sum_next[AW];
              cnt <= cnt_inc;
            end
            if (prod_last) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // clear is ignored here so a completed result is never lost.
          if (out_ready) begin
            if (accept) begin
              acc <= term;
              cnt <= CW'(1);
              ovf <= 1'b0;
              if (!prod_last) begin
                state     <= ACC;
                out_valid <= 1'b0;
              end
            end else begin
              state     <= ACC;
              out_valid <= 1'b0;
              cnt       <= '0;
            end
          end
        end
        default: begin
          state     <= ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a vector-level model (exact wide sums
// of each vector's terms) checked every cycle, plus hand-computed expectations.
module tb_product_accumulator;

  localparam int PW = 64;
  localparam int GUARD = 8;
  localparam int CW = 16;
  localparam int AW = PW + GUARD;
  localparam logic [63:0] PMAX = 64'hFFFF_FFFE_0000_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] product;
  logic          prod_valid, prod_last, prod_ready, clear;
  logic [AW-1:0] sum;
  logic [CW-1:0] count;
  logic          ovf, out_valid, out_ready;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  product_accumulator #(.PW(PW), .GUARD(GUARD), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Product(product), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready), .clear(clear),
    .Sum(sum), .Count(count), .Ovf(ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector-level model: collects the terms of the open vector and, on the last
  // one, computes the exact total in 128 bits to derive Sum, Count and Ovf.
  logic [63:0]   m_terms[$];
  bit            m_pending = 1'b0;
  logic [AW-1:0] m_sum;
  logic [CW-1:0] m_count;
  logic          m_ovf;

  always @(posedge clk) begin
    bit was_pending, ready, acc_term;
    logic [127:0] total;
    if (!rst_n) begin
      m_pending = 1'b0;
      m_terms.delete();
    end else begin
      was_pending = m_pending;
      ready = !was_pending || out_ready;
      acc_term = prod_valid && ready;
      if (was_pending && out_ready) m_pending = 1'b0;
      if (!was_pending && clear) begin
        m_terms.delete();
      end else if (acc_term) begin
        m_terms.push_back(product);
        if (prod_last) begin
          total = '0;
          foreach (m_terms[i]) total += {64'd0, m_terms[i]};
          m_sum = total[AW-1:0];
          m_ovf = (total >> AW) != 0;
          m_count = (m_terms.size() > 65535) ? 16'hFFFF : 16'(m_terms.size());
          m_pending = 1'b1;
          m_terms.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("prod_ready", prod_ready, rst_n && (!m_pending || out_ready));
      check("out_valid", out_valid, m_pending);
      if (m_pending) begin
        check("model_sum", sum, m_sum);
        check("model_count", count, m_count);
        check("model_ovf", ovf, m_ovf);
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] p, input logic l,
                      input logic ordy, input logic clr);
    prod_valid = v;
    product    = p;
    prod_last  = l;
    out_ready  = ordy;
    clear      = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    prod_valid = 1'b0; product = '0; prod_last = 1'b0; out_ready = 1'b0; clear = 1'b0;
    #1;
    check("ready_in_reset", prod_ready, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("reset_sum", sum, 0);
    check("reset_count", count, 0);
    check("reset_ovf", ovf, 0);
    check("reset_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", prod_ready, 1'b1);

    // Single-term vector.
    step(1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b1, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_sum", sum, 72'h00_0000_0001_0000_0000);
    check("single_count", count, 1);
    check("single_ovf", ovf, 0);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("single_retired", out_valid, 0);

    // 256 maximal products: fits exactly in the guard bits.
    for (int i = 0; i < 256; i++) step(1'b1, PMAX, i == 255, 1'b0, 1'b0);
    check("max256_sum", sum, 72'hFF_FFFF_FE00_0000_0100);
    check("max256_count", count, 256);
    check("max256_ovf", ovf, 0);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

    // 257 maximal products: one carry out of AW bits.
    for (int i = 0; i < 257; i++) step(1'b1, PMAX, i == 256, 1'b0, 1'b0);
    check("max257_sum", sum, 72'h00_FFFF_FDFE_0000_0101);
    check("max257_count", count, 257);
    check("max257_ovf", ovf, 1);

    // Backpressure with a clear thrown in: the pending result must not move.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'd77, 1'b0, 1'b0, i == 2);
      check("bp_ready", prod_ready, 0);
      check("bp_sum", sum, 72'h00_FFFF_FDFE_0000_0101);
      check("bp_count", count, 257);
      check("bp_ovf", ovf, 1);
    end
    step(1'b1, 64'd5, 1'b1, 1'b1, 1'b0);
    check("chain_valid", out_valid, 1);
    check("chain_sum", sum, 5);
    check("chain_count", count, 1);
    check("chain_ovf", ovf, 0);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

    // Clear mid-vector drops the partial sum and the same-cycle term.
    step(1'b1, 64'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 64'd4, 1'b0, 1'b1, 1'b0);
    step(1'b1, 64'd100, 1'b0, 1'b1, 1'b1);
    step(1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
    check("clear_sum", sum, 7);
    check("clear_count", count, 1);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

    // Reset mid-vector.
    step(1'b1, 64'd9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'd9, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("midrst_sum", sum, 0);
    check("midrst_count", count, 0);
    check("midrst_valid", out_valid, 0);
    rst_n = 1'b1;
    step(1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
    check("midrst_new_sum", sum, 2);
    check("midrst_new_count", count, 1);
    check("midrst_new_ovf", ovf, 0);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 32x32 Vedic multiplier.
- Consumes its 64-bit Product, one term per accepted handshake, and accumulates terms into a guarded sum.
- Emits one result per vector, for dot-product / MAC use.
- Valid/ready on both sides; a single register stage between the product input and the accumulator.

Parameters:
- PW, 64, product input width; equals 2x the multiplier operand width.
- GUARD, 8, guard bits above PW; accumulator width AW = PW+GUARD.
- CW, 16, term-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- Product  in  PW  unsigned product term from the multiplier.
- prod_valid  in  1  Product is valid this cycle.
- prod_last  in  1  qualifies Product as the final term of the current vector.
- prod_ready  out  1  block can accept a term this cycle.
- clear  in  1  synchronous abort of the partial vector.
- Sum  out  AW  accumulated result.
- Count  out  CW  number of terms in Sum; saturates at all-ones.
- Ovf  out  1  sticky: the vector's sum exceeded AW bits.
- out_valid  out  1  Sum/Count/Ovf hold a completed vector.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_n=0 at clk edge): acc=0, cnt=0, ovf=0, state=ACC, out_valid=0; outputs Sum=0, Count=0, Ovf=0, prod_ready=0 in the reset cycle, then 1.
- States: ACC (collecting terms), DONE (result held).
- Handshakes: accept = prod_valid & prod_ready; result handshake = out_valid & out_ready.
- prod_ready is combinational, with no dependence on prod_valid:
  - ACC: 1.
  - DONE: equals out_ready, so a new vector's first term can be accepted in the same cycle the result is consumed.
- ACC, accept with first=1 (cnt==0): acc <= zero-extended Product; cnt <= 1; ovf <= 0.
- ACC, accept with first=0: {c,acc} <= acc + zext(Product); ovf <= ovf | c; acc wraps mod 2^AW; cnt <= cnt+1, holding at 2^CW-1.
- Accept with prod_last=1:
  - Update acc/cnt/ovf as above; next state DONE; out_valid=1 the following cycle.
  - Latency: last term accepted at edge t -> out_valid high after edge t, i.e. one cycle.
- Sum/Count/Ovf are direct register outputs, always driven; they are meaningful only while out_valid=1 and are stable while out_valid=1 & !out_ready.
- DONE, out_ready=0: hold everything; prod_ready=0.
- DONE, out_ready=1, no accept: out_valid <= 0; cnt <= 0; state ACC. acc/ovf keep their values until the next first term overwrites them.
- DONE, out_ready=1, accept (simultaneous):
  - Result retires.
  - Accepted term starts the new vector: acc <= zext(Product), cnt <= 1, ovf <= 0.
  - If that term also has prod_last=1: stay DONE with out_valid=1, presenting the 1-term vector next cycle.
- clear=1:
  - In ACC: cnt <= 0, ovf <= 0; any same-cycle accepted term is discarded.
  - In DONE: ignored, so completed results are never lost.
  - clear has priority over accept.
- prod_last with cnt saturated: still completes; Count reports 2^CW-1.
- Reset mid-vector or mid-DONE: partial sum and pending result are discarded; outputs return to reset values.
- No combinational path from Product to Sum.
- Widths: all additions are unsigned, AW bits plus carry; no saturation of Sum.

Test Plan:
- Reset then single term: Product=0x0000_0001_0000_0000 with last, out_ready=1 -> next cycle out_valid=1, Sum=0x00_0000_0001_0000_0000, Count=1, Ovf=0; the following cycle out_valid=0.
- Max-product stream: 256 terms of 0xFFFF_FFFE_0000_0001, last on the 256th -> Sum=0xFF_FFFF_FE00_0000_0100, Count=256, Ovf=0.
- Same stream with 257 terms -> Ovf=1, Sum=0x00_FFFF_FDFE_0000_0101, Count=257.
- Backpressure: result pending, out_ready=0 for 5 cycles while prod_valid=1 -> prod_ready=0 throughout, Sum/Count/Ovf stable.
  - Raise out_ready together with a last term Product=5 -> result retires, and the next cycle shows Sum=5, Count=1.
- Clear mid-vector: terms 3, 4, then clear=1 (with prod_valid=1, Product=100), then 7 with last -> Sum=7, Count=1.
- Reset mid-vector: after terms 9, 9, assert rst_n=0 for one cycle, then term 2 with last -> Sum=2, Count=1, Ovf=0.
